adder_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle 8-bit registered adder in the sample datapath. It adds or subtracts two WIDTH-bit unsigned operands, optionally with unsigned saturation, and splits the carry chain across STAGES register stages so that wide operands still close timing. Valid/ready handshakes sit on both sides, and an overflow event counter is included. The block is the arithmetic DUT for the next round of UVM agent, scoreboard and backpressure sequences.

---
 rtl/adder_pipe.sv | 144 ++++++++++++++
 tb/tb_adder_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined WIDTH-bit add/sub with unsigned saturation.
// Carry chain split into STAGES chunks, valid/ready on both sides.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      operand handshake (A, B, op, sat sampled together)
//   A, B                   unsigned operands
//   op                     0 = A+B, 1 = A-B
//   sat                    clip low bits on carry/borrow
//   out_valid/out_ready    result handshake
//   sum                    {carry|borrow, result}
//   ovf                    sum[WIDTH], qualified by out_valid
//   ovf_count              saturating count of consumed results with ovf=1
module adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             op,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int C = WIDTH / STAGES;

    logic stall;
    logic adv;

    assign stall    = out_valid && !out_ready;
    assign adv      = !stall;
    assign in_ready = adv;

    // Stage k adds chunk k. Operand bits above chunk k travel upward in
    // shrinking delay registers; finished low result bits grow each stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = WIDTH - k * C;
        localparam int HW = (k + 1) * C;

        logic [RW-1:0] a_i;
        logic [RW-1:0] b_i;
        logic          op_i;
        logic          sat_i;
        logic          cin;
        logic          v_i;
        logic [C-1:0]  b_c;
        logic [C:0]    csum;
        logic [HW-1:0] r_raw;
        logic [HW-1:0] r_d;
        logic          c_d;

        logic          v_q;
        logic          c_q;
        logic [HW-1:0] r_q;

        if (k == 0) begin : g_head
            assign a_i   = A;
            assign b_i   = B;
            assign op_i  = op;
            assign sat_i = sat;
            // Carry-in of op supplies the +1 of A + ~B + 1.
            assign cin   = op;
            assign v_i   = in_valid;
            assign r_raw = csum[C-1:0];
        end else begin : g_link
            assign a_i   = g_st[k-1].g_body.a_q;
            assign b_i   = g_st[k-1].g_body.b_q;
            assign op_i  = g_st[k-1].g_body.op_q;
            assign sat_i = g_st[k-1].g_body.sat_q;
            assign cin   = g_st[k-1].c_q;
            assign v_i   = g_st[k-1].v_q;
            assign r_raw = {csum[C-1:0], g_st[k-1].r_q};
        end

        assign b_c  = op_i ? ~b_i[C-1:0] : b_i[C-1:0];
        assign csum = {1'b0, a_i[C-1:0]} + {1'b0, b_c} + {{C{1'b0}}, cin};

        if (k == STAGES - 1) begin : g_tail
            logic flag;

            // Borrow is the inverted carry when subtracting.
            assign flag = op_i ^ csum[C];
            assign c_d  = flag;
            // Clip to all ones on add overflow, all zeros on borrow.
            assign r_d  = (sat_i && flag) ? {HW{~op_i}} : r_raw;
        end else begin : g_body
            logic [RW-C-1:0] a_q;
            logic [RW-C-1:0] b_q;
            logic            op_q;
            logic            sat_q;

            assign c_d = csum[C];
            assign r_d = r_raw;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    op_q  <= 1'b0;
                    sat_q <= 1'b0;
                end else if (adv) begin
                    a_q   <= a_i[RW-1:C];
                    b_q   <= b_i[RW-1:C];
                    op_q  <= op_i;
                    sat_q <= sat_i;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else if (adv) begin
                v_q <= v_i;
                c_q <= c_d;
                r_q <= r_d;
            end
        end
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign ovf       = g_st[STAGES-1].c_q;
    assign sum       = {g_st[STAGES-1].c_q, g_st[STAGES-1].r_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_count <= '0;
        end else if (out_valid && out_ready && ovf && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed and scoreboarded checks of adder_pipe in
// three configurations (8/2/16, 8/2/2 counter, 16/4/16).
module tb_adder_pipe;

    logic clk;
    logic reset;

    logic        iv0, ir0, ov0, or0, op0, sat0, ovf0;
    logic [7:0]  a0, b0;
    logic [8:0]  sum0;
    logic [15:0] cnt0;

    logic        iv1, ir1, ov1, or1, op1, sat1, ovf1;
    logic [7:0]  a1, b1;
    logic [8:0]  sum1;
    logic [1:0]  cnt1;

    logic        iv2, ir2, ov2, or2, op2, sat2, ovf2;
    logic [15:0] a2, b2;
    logic [16:0] sum2;
    logic [15:0] cnt2;

    int n_assert;
    int n_fail;

    int idx, st, seen, exp1, k1, res1, sent, cyc;
    logic [8:0]  got[$];
    logic [16:0] sb[$];
    logic [16:0] expv;

    adder_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset),
        .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
        .op(op0), .sat(sat0),
        .out_valid(ov0), .out_ready(or0),
        .sum(sum0), .ovf(ovf0), .ovf_count(cnt0)
    );

    adder_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(2)) u1 (
        .clk(clk), .reset(reset),
        .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .op(op1), .sat(sat1),
        .out_valid(ov1), .out_ready(or1),
        .sum(sum1), .ovf(ovf1), .ovf_count(cnt1)
    );

    adder_pipe #(.WIDTH(16), .STAGES(4), .CNT_W(16)) u2 (
        .clk(clk), .reset(reset),
        .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
        .op(op2), .sat(sat2),
        .out_valid(ov2), .out_ready(or2),
        .sum(sum2), .ovf(ovf2), .ovf_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic o, input logic s);
        logic [16:0] t;
        logic        f;
        if (o) begin
            t = {1'b0, a} - {1'b0, b};
            f = (a < b);
        end else begin
            t = {1'b0, a} + {1'b0, b};
            f = t[16];
        end
        if (s && f) t[15:0] = o ? 16'h0000 : 16'hFFFF;
        return {f, t[15:0]};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // One isolated beat through u0; caller sits just after a rising edge.
    task automatic beat0(input string tag, input logic [7:0] a,
                         input logic [7:0] b, input logic o, input logic s,
                         input logic [8:0] es, input logic [15:0] ecnt);
        iv0 = 1'b1; a0 = a; b0 = b; op0 = o; sat0 = s;
        @(posedge clk); #1;
        iv0 = 1'b0;
        chk({tag, ".early"}, 32'(ov0), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".valid"}, 32'(ov0), 32'd1);
        chk({tag, ".sum"}, 32'(sum0), 32'(es));
        chk({tag, ".ovf"}, 32'(ovf0), 32'(es[8]));
        @(posedge clk); #1;
        chk({tag, ".cnt"}, 32'(cnt0), 32'(ecnt));
        chk({tag, ".drain"}, 32'(ov0), 32'd0);
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        reset = 1'b1;
        iv0 = 0; a0 = 0; b0 = 0; op0 = 0; sat0 = 0; or0 = 1;
        iv1 = 0; a1 = 0; b1 = 0; op1 = 0; sat1 = 0; or1 = 1;
        iv2 = 0; a2 = 0; b2 = 0; op2 = 0; sat2 = 0; or2 = 1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst0.valid", 32'(ov0), 32'd0);
        chk("rst0.sum", 32'(sum0), 32'd0);
        chk("rst0.cnt", 32'(cnt0), 32'd0);
        chk("rst0.ready", 32'(ir0), 32'd1);

        // Two overflowing beats in flight, then reset with handshakes active.
        iv0 = 1; a0 = 8'hFF; b0 = 8'h01;
        @(posedge clk); #1;
        b0 = 8'h02;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        iv0 = 0;
        chk("rst1.valid", 32'(ov0), 32'd0);
        chk("rst1.sum", 32'(sum0), 32'd0);
        chk("rst1.ovf", 32'(ovf0), 32'd0);
        chk("rst1.cnt", 32'(cnt0), 32'd0);
        chk("rst1.ready", 32'(ir0), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst1.quiet", 32'(ov0), 32'd0);
        end

        beat0("add_chunk", 8'h0F, 8'h01, 1'b0, 1'b0, 9'h010, 16'd0);
        beat0("add_wrap", 8'd200, 8'd100, 1'b0, 1'b0, 9'h12C, 16'd1);
        beat0("add_sat", 8'd200, 8'd100, 1'b0, 1'b1, 9'h1FF, 16'd2);
        beat0("sub_wrap", 8'd5, 8'd10, 1'b1, 1'b0, 9'h1FB, 16'd3);
        beat0("sub_sat", 8'd5, 8'd10, 1'b1, 1'b1, 9'h100, 16'd4);
        beat0("sub_ok", 8'd10, 8'd5, 1'b1, 1'b0, 9'h005, 16'd4);

        // Backpressure: 3 stalled cycles from the first out_valid.
        idx = 0; st = 0; seen = 0;
        for (int c = 0; c < 16; c++) begin
            iv0 = (idx < 4); a0 = 8'(idx + 1); b0 = 8'd1;
            op0 = 0; sat0 = 0;
            if (ov0 && seen == 0) seen = 1;
            or0 = !(seen != 0 && st < 3);
            @(negedge clk);
            if (seen != 0 && st < 3) begin
                chk("bp.stall_ready", 32'(ir0), 32'd0);
                chk("bp.hold_valid", 32'(ov0), 32'd1);
                chk("bp.hold_sum", 32'(sum0), 32'h002);
                st++;
            end else begin
                chk("bp.ready", 32'(ir0), 32'd1);
            end
            if (iv0 && ir0) idx++;
            if (ov0 && or0) got.push_back(sum0);
            @(posedge clk); #1;
        end
        iv0 = 0; or0 = 1;
        chk("bp.count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp.res%0d", i),
                32'((i < got.size()) ? got[i] : 9'h1FF), 32'(i + 2));
        end

        // Counter saturation with CNT_W=2.
        exp1 = 0; k1 = 0; res1 = 0;
        for (int c = 0; c < 10; c++) begin
            iv1 = (k1 < 5); a1 = 8'hFF; b1 = 8'h01;
            op1 = 0; sat1 = 0; or1 = 1;
            @(negedge clk);
            chk("cnt.value", 32'(cnt1), 32'(exp1));
            if (ov1) begin
                chk("cnt.sum", 32'(sum1), 32'h100);
                exp1 = (exp1 == 3) ? 3 : exp1 + 1;
                res1++;
            end
            if (iv1 && ir1) k1++;
            @(posedge clk); #1;
        end
        iv1 = 0;
        chk("cnt.final", 32'(cnt1), 32'd3);
        chk("cnt.results", 32'(res1), 32'd5);

        // Wide 4-stage: carry ripples through every chunk.
        iv2 = 1; a2 = 16'hFFFF; b2 = 16'h0001; op2 = 0; sat2 = 0; or2 = 1;
        @(posedge clk); #1;
        iv2 = 0;
        repeat (3) begin
            chk("w.early", 32'(ov2), 32'd0);
            @(posedge clk); #1;
        end
        chk("w.valid", 32'(ov2), 32'd1);
        chk("w.sum", 32'(sum2), 32'h10000);
        @(posedge clk); #1;
        chk("w.drain", 32'(ov2), 32'd0);

        // Random add/sub/sat stream with random backpressure.
        sent = 0; cyc = 0;
        while ((sent < 60 || sb.size() != 0) && cyc < 3000) begin
            iv2  = (sent < 60) && ($urandom_range(0, 3) != 0);
            a2   = pick();
            b2   = pick();
            op2  = 1'($urandom_range(0, 1));
            sat2 = 1'($urandom_range(0, 1));
            or2  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (ov2 && or2) begin
                if (sb.size() != 0) begin
                    expv = sb.pop_front();
                    chk("rnd.sum", 32'(sum2), 32'(expv));
                    chk("rnd.ovf", 32'(ovf2), 32'(expv[16]));
                end else begin
                    chk("rnd.spurious", 32'(ov2), 32'd0);
                end
            end
            if (iv2 && ir2) begin
                sb.push_back(model(a2, b2, op2, sat2));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        iv2 = 0; or2 = 1;
        chk("rnd.done", 32'(sent == 60 && sb.size() == 0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
